vco_band_cal: RTL and testbench
===============================

// Module: vco_band_cal
// PURPOSE
//  Automatic coarse-band selector for daisyVco: drives the 5-bit subrange code D and converges it by
//  a 5-step successive-approximation search. Each step counts divided-VCO edges over a fixed window
//  of clk cycles. Sits between the PLL control logic and the VCO D input; the loop stays open
//  (control held at mid-scale) while it runs.
//  D is inverted w.r.t. frequency: sub_nr = ~D; D=31 -> slowest subrange 0, D=0 -> fastest subrange 31.
// PARAMETERS
//  CNT_W          16    width of edge counter / target_cnt / cnt_last
//  WIN_CYCLES     1024  measurement window length in clk cycles (>=4)
//  SETTLE_CYCLES  64    wait after each D change before measuring (>=1)
// PORTS
//  clk         in   1      reference clock; single clock domain
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      1-cycle pulse: begin calibration (ignored while busy)
//  fdiv_in     in   1      divided VCO output, asynchronous, period >= 4 clk cycles
//  target_cnt  in   CNT_W  expected edge count per window at desired frequency; sampled on accepted start
//  d_out       out  5      subrange code to VCO D port
//  hold_mid    out  1      1 = loop must force VCO control to 0.5 (mid-scale)
//  busy        out  1      calibration in progress
//  done        out  1      1-cycle pulse when final d_out is valid
//  cnt_last    out  CNT_W  edge count of most recent window
// BEHAVIOUR
//  Reset: sub_nr=5'b10000 (d_out=5'd15), hold_mid=0, busy=0, done=0, cnt_last=0, state=IDLE.
//  Sync: fdiv_in -> 2-flop synchronizer -> rising-edge detect (1-cycle pulse); sync regs reset to 0.
//  FSM states: IDLE, SETTLE, MEASURE, DECIDE, FINISH.
//   IDLE:    on start: latch target_cnt; sub_nr=5'b10000; bit_idx=4; busy=1; hold_mid=1 -> SETTLE.
//   SETTLE:  count SETTLE_CYCLES cycles -> MEASURE; clear edge counter.
//   MEASURE: exactly WIN_CYCLES cycles; each edge pulse in the window increments the counter;
//            counter saturates at 2^CNT_W-1 (no wrap). Then cnt_last<=count -> DECIDE.
//   DECIDE (1 cycle): if cnt_last > target, clear sub_nr[bit_idx] (too fast); equal or below -> keep.
//            If bit_idx==0 -> FINISH; else bit_idx--, set sub_nr[bit_idx-1], -> SETTLE.
//   FINISH (1 cycle): done=1, busy=0, hold_mid=0 -> IDLE; d_out holds its value until the next start.
//  d_out = ~sub_nr, registered. It changes only on the start cycle and in DECIDE.
//  Latency: start to done = 5*(SETTLE_CYCLES+WIN_CYCLES+1)+2 clk cycles.
//  Boundaries:
//   - start while busy: ignored; start in the FINISH cycle: ignored.
//   - start in the same cycle done is seen in IDLE: accepted normally.
//   - fdiv_in static: count=0 every step -> final sub_nr=31, d_out=0.
//   - target_cnt=0 with any edge: every bit cleared -> d_out=31.
//   - rst_n low mid-calibration: immediate return to reset values; no done pulse.
//   - Edge pulse in the last MEASURE cycle is counted; pulses in SETTLE/DECIDE are not.
// STRUCTURE
//  Package daisy_vco_pkg: D_W=5, SUBS=32, state enum (IDLE/SETTLE/MEASURE/DECIDE/FINISH),
//  sub_nr<->D inversion function.
//  Sub-module vco_edge_counter: synchronizer, edge detect, gated saturating counter
//  (ports clk, rst_n, fdiv_in, clr, en, count).
//  The top holds the FSM, SAR register, timers and outputs.
// TESTING  (bench VCO model: edges per window = 100 + 4*sub_nr, WIN=1024, SETTLE=64)
//  1 reset: assert rst_n=0 -> d_out=15, busy=0, done=0, hold_mid=0, cnt_last=0.
//  2 target=180 -> trials sub_nr 16 keep (164), 24 clear (196), 20 keep (180, equal), 22 clear,
//    21 clear -> d_out=11; done exactly 5*(64+1024+1)+2 cycles after start.
//  3 target=1000 -> d_out=0; target=0 -> d_out=31; fdiv_in stuck low, target=10 -> d_out=0.
//  4 second start pulse during MEASURE of step 2 -> ignored; same result and timing as scenario 2.
//  5 rst_n pulsed low during step 3 -> reset values, no done; new start -> clean full run, d_out=11.
//  6 fdiv_in at 1 edge per 4 clk with CNT_W=8 and target=255 -> count saturates at 255,
//    never wraps; cnt_last=255.

Source files
------------

// File: rtl/daisy_vco_pkg.sv
// Shared types and helpers for the daisyVco coarse-band calibration slice.
package daisy_vco_pkg;

  localparam int D_W  = 5;
  localparam int SUBS = 32;

  localparam logic [D_W-1:0] SUB_MID = D_W'(SUBS / 2);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DECIDE,
    FINISH
  } cal_state_e;

  // The VCO D port counts the opposite way to frequency: a higher subrange gives a lower D.
  function automatic logic [D_W-1:0] sub_to_d(input logic [D_W-1:0] sub_nr);
    return ~sub_nr;
  endfunction

endpackage

// File: rtl/vco_edge_counter.sv
// Synchronises the divided VCO clock, detects rising edges and counts them while enabled.
module vco_edge_counter
  import daisy_vco_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fdiv_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Bits [1:0] form the synchroniser, bit [2] holds the previous value for edge detection.
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             edge_pulse;

  always_comb begin
    sync_d     = {sync_q[1:0], fdiv_in};
    edge_pulse = sync_q[1] & ~sync_q[2];
    count_d    = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && edge_pulse && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      count_q <= '0;
    end else begin
      sync_q  <= sync_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vco_band_cal.sv
// Coarse-band SAR search for daisyVco: five settle/measure/decide steps converge the subrange code.
// state   | meaning
// IDLE    | waiting for start, d_out holds the last result
// SETTLE  | VCO settling after a D change, edge counter held clear
// MEASURE | counting divided-VCO edges over the window
// DECIDE  | resolve current SAR bit, trial the next one
// FINISH  | raise done, drop busy and hold_mid
module vco_band_cal
  import daisy_vco_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int WIN_CYCLES    = 1024,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             fdiv_in,
  input  logic [CNT_W-1:0] target_cnt,
  output logic [D_W-1:0]   d_out,
  output logic             hold_mid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_last
);

  localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] WIN_LD = TMR_W'(WIN_CYCLES - 1);
  localparam logic [TMR_W-1:0] SET_LD = TMR_W'(SETTLE_CYCLES - 1);

  cal_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [D_W-1:0]   sub_nr_q, sub_nr_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_last_q, cnt_last_d;
  logic             busy_q, busy_d;
  logic             hold_mid_q, hold_mid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] edge_cnt;

  vco_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .fdiv_in (fdiv_in),
    .clr     (state_q == SETTLE),
    .en      (state_q == MEASURE),
    .count   (edge_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      sub_nr_q   <= SUB_MID;
      bit_idx_q  <= 3'd4;
      tgt_q      <= '0;
      cnt_last_q <= '0;
      busy_q     <= 1'b0;
      hold_mid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      sub_nr_q   <= sub_nr_d;
      bit_idx_q  <= bit_idx_d;
      tgt_q      <= tgt_d;
      cnt_last_q <= cnt_last_d;
      busy_q     <= busy_d;
      hold_mid_q <= hold_mid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (tmr_q == '0) state_d = MEASURE;
      MEASURE: if (tmr_q == '0) state_d = DECIDE;
      DECIDE:  state_d = (bit_idx_q == 3'd0) ? FINISH : SETTLE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The edge counter is frozen outside MEASURE, so in DECIDE it already includes a last-cycle edge.
  always_comb begin
    tmr_d      = tmr_q;
    sub_nr_d   = sub_nr_q;
    bit_idx_d  = bit_idx_q;
    tgt_d      = tgt_q;
    cnt_last_d = cnt_last_q;
    busy_d     = busy_q;
    hold_mid_d = hold_mid_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d      = target_cnt;
          sub_nr_d   = SUB_MID;
          bit_idx_d  = 3'd4;
          busy_d     = 1'b1;
          hold_mid_d = 1'b1;
          tmr_d      = SET_LD;
        end
      end
      SETTLE:  tmr_d = (tmr_q == '0) ? WIN_LD : tmr_q - TMR_W'(1);
      MEASURE: if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
      DECIDE: begin
        cnt_last_d = edge_cnt;
        if (edge_cnt > tgt_q) sub_nr_d[bit_idx_q] = 1'b0;
        if (bit_idx_q != 3'd0) begin
          bit_idx_d                      = bit_idx_q - 3'd1;
          sub_nr_d[bit_idx_q - 3'd1]     = 1'b1;
          tmr_d                          = SET_LD;
        end
      end
      FINISH: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        hold_mid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign d_out    = sub_to_d(sub_nr_q);
  assign hold_mid = hold_mid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cnt_last = cnt_last_q;

endmodule

// File: tb/tb_vco_band_cal.sv
// Bench for vco_band_cal: behavioural VCO (edges per window = 100 + 4*subrange) and SAR reference model.
module tb_vco_band_cal;

  localparam int S   = 64;
  localparam int W   = 1024;
  localparam int P   = S + W + 1;
  localparam int LAT = 5 * P + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        fdiv_in = 1'b0;
  logic [15:0] target_cnt;
  logic [4:0]  d_out;
  logic        hold_mid, busy, done;
  logic [15:0] cnt_last;

  logic        start_s;
  logic        fdiv_s = 1'b0;
  logic [7:0]  target_s;
  logic [4:0]  d_out_s;
  logic        hold_mid_s, busy_s, done_s;
  logic [7:0]  cnt_last_s;

  int  n_chk  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  bit  stuck  = 1'b0;

  vco_band_cal #(.CNT_W(16), .WIN_CYCLES(W), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fdiv_in(fdiv_in), .target_cnt(target_cnt),
    .d_out(d_out), .hold_mid(hold_mid), .busy(busy), .done(done), .cnt_last(cnt_last)
  );

  vco_band_cal #(.CNT_W(8), .WIN_CYCLES(W), .SETTLE_CYCLES(S)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .fdiv_in(fdiv_s), .target_cnt(target_s),
    .d_out(d_out_s), .hold_mid(hold_mid_s), .busy(busy_s), .done(done_s), .cnt_last(cnt_last_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Phase accumulator: N full turns per 1024 clk cycles gives exactly N rising edges in any window.
  initial begin
    int acc = 0;
    int ph  = 0;
    forever begin
      @(posedge clk);
      #2;
      if (stuck) begin
        fdiv_in = 1'b0;
      end else begin
        acc     = (acc + 100 + 4 * (31 - int'(d_out))) % 1024;
        fdiv_in = (acc >= 512);
      end
      ph     = (ph + 1) % 4;
      fdiv_s = (ph >= 2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int vco_edges(input int sub, input bit stk, input int cmax);
    int e;
    e = stk ? 0 : 100 + 4 * sub;
    return (e > cmax) ? cmax : e;
  endfunction

  function automatic int model_d(input int tgt, input bit stk, input int cmax, output int last);
    int s;
    int trial;
    s    = 0;
    last = 0;
    for (int b = 4; b >= 0; b--) begin
      trial = s | (1 << b);
      last  = vco_edges(trial, stk, cmax);
      if (last <= tgt) s = trial;
    end
    return 31 - s;
  endfunction

  // inject: 0 none, 1 extra start in step-2 MEASURE, 2 reset in step 3, 3 start in FINISH cycle
  task automatic run_cal(input string tag, input int tgt, input int inject);
    int  exp_d, exp_last, t0, n_done;
    bit  seen;
    exp_d      = model_d(tgt, stuck, 65535, exp_last);
    target_cnt = tgt[15:0];
    start      = 1'b1;
    t0         = cyc;
    seen       = 1'b0;
    for (int i = 0; i < LAT + 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      start = (inject == 1 && cyc - t0 == P + S + 200) || (inject == 3 && cyc - t0 == 5 * P + 1);
      if (i == 0) begin
        chk({tag, "_busy_run"}, busy, 1);
        chk({tag, "_hold_run"}, hold_mid, 1);
        chk({tag, "_done_run"}, done, 0);
      end
      if (inject == 2 && cyc - t0 == 2 * P + S + 10) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_d"}, d_out, 15);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_hold"}, hold_mid, 0);
        chk({tag, "_rst_cnt"}, cnt_last, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        n_done = 0;
        repeat (20) begin
          @(posedge clk);
          #1;
          if (done) n_done++;
        end
        chk({tag, "_no_done"}, n_done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        return;
      end
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, cyc - t0, LAT);
    chk({tag, "_d_out"}, d_out, exp_d);
    chk({tag, "_cnt_last"}, cnt_last, exp_last);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_hold_end"}, hold_mid, 0);
    if (inject == 3) begin
      @(posedge clk);
      #1;
      chk({tag, "_finish_start_ignored"}, busy, 0);
    end
  endtask

  initial begin
    int  t0;
    bit  seen;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_s    = 1'b0;
    target_cnt = '0;
    target_s   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_d_out", d_out, 15);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hold_mid", hold_mid, 0);
    chk("reset_cnt_last", cnt_last, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_cal("t180", 180, 0);
    run_cal("t180_dbl_start", 180, 1);
    run_cal("t1000_finish_start", 1000, 3);
    run_cal("t0", 0, 0);
    run_cal("abort", 180, 2);
    run_cal("t180_rerun", 180, 0);
    stuck = 1'b1;
    run_cal("stuck_low", 10, 0);
    stuck = 1'b0;
    repeat (2) run_cal("rand", int'($urandom_range(120, 230)), 0);

    target_s = 8'd255;
    start_s  = 1'b1;
    t0       = cyc;
    seen     = 1'b0;
    for (int i = 0; i < LAT + 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      start_s = 1'b0;
      if (done_s) seen = 1'b1;
    end
    chk("sat_done_seen", seen, 1);
    chk("sat_latency", cyc - t0, LAT);
    chk("sat_cnt_last", cnt_last_s, 255);
    chk("sat_d_out", d_out_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
